store_write_buffer: RTL and testbench
=====================================

STORE_WRITE_BUFFER -- requirements
Module: store_write_buffer

Interface
Parameters:
REQ-001 SHALL provide parameter DEPTH, 4, number of buffer entries (power of two, >=2).
REQ-002 SHALL provide parameter DATA_W, 32, width of J/K/L/M registers and store data.
REQ-003 SHALL provide parameter ADDR_W, 8, width of the generated store address.
Ports:
REQ-004 SHALL have port Clk, input, 1, single clock; all state updates on rising edge.
REQ-005 SHALL have port Rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port data_we, input, 1, store command from controller; a push request.
REQ-007 SHALL have port jklm_select, input, 2, source select: 00=J, 01=K, 10=L, 11=M.
REQ-008 SHALL have ports regJ, regK, regL, regM, input, DATA_W each, store-source register values.
REQ-009 SHALL have port mem_valid, output, 1, head entry available to memory.
REQ-010 SHALL have port mem_ready, input, 1, memory accepts head entry this cycle.
REQ-011 SHALL have port mem_addr, output, ADDR_W, address of head entry.
REQ-012 SHALL have port mem_data, output, DATA_W, data of head entry.
REQ-013 SHALL have port count, output, log2(DEPTH)+1, current occupancy.
REQ-014 SHALL have ports full and empty, output, 1 each, occupancy flags.
REQ-015 SHALL have port overflow, output, 1, sticky flag: a store was dropped.

Function
REQ-016 Push SHALL occur on a rising Clk edge when data_we=1 and (full=0 or a pop occurs in the same cycle).
REQ-017 Pushed entry SHALL be {addr_ctr, selected register sampled at that edge}; addr_ctr SHALL then increment by 1, wrapping 2^ADDR_W-1 -> 0.
REQ-018 Pop SHALL occur on a rising edge when mem_valid=1 and mem_ready=1.
REQ-019 mem_valid SHALL equal !empty; no fall-through: entry pushed at edge N is visible at the outputs after edge N, never combinationally.
REQ-020 mem_addr/mem_data SHALL remain stable while mem_valid=1 and mem_ready=0.
REQ-021 Entries SHALL leave in push order (FIFO); read/write pointers SHALL wrap modulo DEPTH.
REQ-022 Simultaneous push and pop SHALL leave count unchanged, including when full and when count=1 (next head is the new entry).
REQ-023 Push when full without a simultaneous pop SHALL be dropped: FIFO state and addr_ctr unchanged, overflow set to 1.
REQ-024 overflow SHALL stay 1 until reset.
REQ-025 mem_ready when empty SHALL have no effect.
REQ-026 full SHALL equal (count==DEPTH); empty SHALL equal (count==0).

Reset
REQ-027 Rst_n=0 SHALL immediately, without Clk, clear pointers, count, addr_ctr and overflow; set empty=1, full=0, mem_valid=0.
REQ-028 Reset mid-operation SHALL discard all buffered entries; storage contents need not be cleared, and mem_addr/mem_data are don't-care while mem_valid=0.
REQ-029 Deassertion of Rst_n SHALL take effect at the next rising Clk edge; the first push after reset SHALL receive address 0.

Configuration
REQ-030 Macro STORE_BUF_PARITY_EN, when defined, SHALL add output port mem_parity, 1 bit, equal to the even parity (XOR) of mem_data, computed at push and stored per entry.
REQ-031 Without STORE_BUF_PARITY_EN, port mem_parity and its storage SHALL not exist; all other behaviour SHALL be identical.

Verification
REQ-032 Reset, then data_we=1, jklm_select=10, regL=0xDEADBEEF for one edge, mem_ready=0 -> next cycle mem_valid=1, mem_addr=0x00, mem_data=0xDEADBEEF, count=1; holds while mem_ready=0.
REQ-033 Four pushes selecting J,K,L,M (values 1,2,3,4), mem_ready=0 -> full=1, count=4; a fifth push -> overflow=1, count=4; then draining with mem_ready=1 yields addr/data 0/1, 1/2, 2/3, 3/4, then empty=1.
REQ-034 Full buffer, data_we=1 and mem_ready=1 on the same edge -> count stays 4, overflow stays 0, new entry gets addr 4 and is popped last.
REQ-035 256 pushes and pops -> addresses 0x00..0xFF then wrap to 0x00 on the 257th push.
REQ-036 Three entries buffered, Rst_n pulsed low between edges -> mem_valid=0, count=0, overflow=0 immediately; next push gets addr 0.
REQ-037 With STORE_BUF_PARITY_EN, pushed data 0x00000007 -> mem_parity=1; data 0x00000003 -> mem_parity=0.

Source files
------------

// File: rtl/store_write_buffer.sv
// Store write buffer: FIFO of {address, J/K/L/M data} entries drained to memory.
// Define STORE_BUF_PARITY_EN to add a per-entry even-parity bit on mem_parity.
module store_write_buffer #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 8
) (
  input  logic                       Clk,
  input  logic                       Rst_n,
  input  logic                       data_we,
  input  logic [1:0]                 jklm_select,
  input  logic [DATA_W-1:0]          regJ,
  input  logic [DATA_W-1:0]          regK,
  input  logic [DATA_W-1:0]          regL,
  input  logic [DATA_W-1:0]          regM,
  output logic                       mem_valid,
  input  logic                       mem_ready,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_data,
`ifdef STORE_BUF_PARITY_EN
  output logic                       mem_parity,
`endif
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty,
  output logic                       overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [ADDR_W-1:0] addr_ctr_q, addr_ctr_d;
  logic              overflow_q, overflow_d;

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [DATA_W-1:0] data_mem [DEPTH];
`ifdef STORE_BUF_PARITY_EN
  logic              par_mem  [DEPTH];
`endif

  logic              push;
  logic              pop;
  logic [DATA_W-1:0] sel_data;

  always_comb begin
    unique case (jklm_select)
      2'b00: sel_data = regJ;
      2'b01: sel_data = regK;
      2'b10: sel_data = regL;
      2'b11: sel_data = regM;
    endcase
  end

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign mem_valid = ~empty;
  assign pop       = mem_valid & mem_ready;
  // A full buffer still accepts a store when the head leaves on the same edge.
  assign push      = data_we & (~full | pop);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    addr_ctr_d = addr_ctr_q;
    overflow_d = overflow_q | (data_we & ~push);
    if (push) begin
      wr_ptr_d   = wr_ptr_q + PW'(1);
      addr_ctr_d = addr_ctr_q + ADDR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      addr_ctr_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      addr_ctr_q <= addr_ctr_d;
      overflow_q <= overflow_d;
    end
  end

  // Entry storage needs no reset; pointers alone define what is valid.
  always_ff @(posedge Clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= addr_ctr_q;
      data_mem[wr_ptr_q] <= sel_data;
`ifdef STORE_BUF_PARITY_EN
      par_mem[wr_ptr_q]  <= ^sel_data;
`endif
    end
  end

  assign mem_addr   = addr_mem[rd_ptr_q];
  assign mem_data   = data_mem[rd_ptr_q];
`ifdef STORE_BUF_PARITY_EN
  assign mem_parity = par_mem[rd_ptr_q];
`endif
  assign count      = count_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_store_write_buffer.sv
// Bench for store_write_buffer: vector table, corner sequences, random vs queue model.
module tb_store_write_buffer;

  localparam int DEPTH = 4;
  localparam int DW    = 32;
  localparam int AW    = 8;

  logic          Clk = 1'b0;
  logic          Rst_n = 1'b0;
  logic          data_we = 1'b0;
  logic [1:0]    jklm_select = 2'b00;
  logic [DW-1:0] regJ = '0, regK = '0, regL = '0, regM = '0;
  logic          mem_valid;
  logic          mem_ready = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
`ifdef STORE_BUF_PARITY_EN
  logic          mem_parity;
`endif
  logic [2:0]    count;
  logic          full, empty, overflow;

  store_write_buffer #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .data_we(data_we),
    .jklm_select(jklm_select),
    .regJ(regJ), .regK(regK), .regL(regL), .regM(regM),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_data(mem_data),
`ifdef STORE_BUF_PARITY_EN
    .mem_parity(mem_parity),
`endif
    .count(count), .full(full), .empty(empty),
    .overflow(overflow)
  );

  always #5 Clk = ~Clk;

  int vecs = 0;
  int errs = 0;

  logic [AW+DW-1:0] mq [$];
  int unsigned      m_ctr = 0;
  bit               m_ovf = 1'b0;

  typedef struct {
    bit          we;
    logic [1:0]  sel;
    logic [31:0] val;
    bit          rdy;
    bit          e_valid;
    logic [7:0]  e_addr;
    logic [31:0] e_data;
    int          e_count;
    bit          e_full;
    bit          e_ovf;
  } vec_t;

  vec_t tbl [9];

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive(bit we, logic [1:0] s, logic [31:0] v, bit rdy);
    data_we     = we;
    jklm_select = s;
    regJ = (s == 2'd0) ? v : ~v;
    regK = (s == 2'd1) ? v : v ^ 32'h0F0F_0F0F;
    regL = (s == 2'd2) ? v : v + 32'h1111;
    regM = (s == 2'd3) ? v : {v[15:0], v[31:16]} ^ 32'h1;
    mem_ready = rdy;
  endtask

  task automatic model_reset();
    mq.delete();
    m_ctr = 0;
    m_ovf = 1'b0;
  endtask

  task automatic model_check();
    logic [AW+DW-1:0] h;
    chk("valid", 64'(mem_valid), 64'(mq.size() != 0));
    chk("count", 64'(count), 64'(mq.size()));
    chk("full", 64'(full), 64'(mq.size() == DEPTH));
    chk("empty", 64'(empty), 64'(mq.size() == 0));
    chk("ovf", 64'(overflow), 64'(m_ovf));
    if (mq.size() != 0) begin
      h = mq[0];
      chk("addr", 64'(mem_addr), 64'(h[AW+DW-1:DW]));
      chk("data", 64'(mem_data), 64'(h[DW-1:0]));
`ifdef STORE_BUF_PARITY_EN
      chk("parity", 64'(mem_parity), 64'(^h[DW-1:0]));
`endif
    end
  endtask

  // Model advances on the inputs present before the edge, then DUT is compared.
  task automatic tick();
    logic [DW-1:0] sv;
    bit pop, push;
    unique case (jklm_select)
      2'd0: sv = regJ;
      2'd1: sv = regK;
      2'd2: sv = regL;
      2'd3: sv = regM;
    endcase
    pop  = (mq.size() > 0) && mem_ready;
    push = data_we && ((mq.size() < DEPTH) || pop);
    if (data_we && !push) m_ovf = 1'b1;
    if (pop) void'(mq.pop_front());
    if (push) begin
      mq.push_back({m_ctr[AW-1:0], sv});
      m_ctr = (m_ctr + 1) % (1 << AW);
    end
    @(posedge Clk);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    drive(0, 2'd0, 32'h0, 0);
    #2;
    Rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
  endtask

  initial begin
    tbl[0] = '{1, 2'd0, 32'd1, 0, 1, 8'd0, 32'd1, 1, 0, 0};
    tbl[1] = '{1, 2'd1, 32'd2, 0, 1, 8'd0, 32'd1, 2, 0, 0};
    tbl[2] = '{1, 2'd2, 32'd3, 0, 1, 8'd0, 32'd1, 3, 0, 0};
    tbl[3] = '{1, 2'd3, 32'd4, 0, 1, 8'd0, 32'd1, 4, 1, 0};
    tbl[4] = '{1, 2'd0, 32'd5, 0, 1, 8'd0, 32'd1, 4, 1, 1};
    tbl[5] = '{0, 2'd0, 32'd0, 1, 1, 8'd1, 32'd2, 3, 0, 1};
    tbl[6] = '{0, 2'd0, 32'd0, 1, 1, 8'd2, 32'd3, 2, 0, 1};
    tbl[7] = '{0, 2'd0, 32'd0, 1, 1, 8'd3, 32'd4, 1, 0, 1};
    tbl[8] = '{0, 2'd0, 32'd0, 1, 0, 8'd0, 32'd0, 0, 0, 1};

    #2;
    chk("rst_valid", 64'(mem_valid), 64'd0);
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_empty", 64'(empty), 64'd1);
    chk("rst_full", 64'(full), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;

    // Single push, then hold with mem_ready low
    drive(1, 2'd2, 32'hDEADBEEF, 0);
    tick();
    chk("one_addr", 64'(mem_addr), 64'h00);
    chk("one_data", 64'(mem_data), 64'hDEADBEEF);
    chk("one_count", 64'(count), 64'd1);
    drive(0, 2'd0, 32'h0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold_addr", 64'(mem_addr), 64'h00);
      chk("hold_data", 64'(mem_data), 64'hDEADBEEF);
    end

    // Fill, overflow, drain from the vector table
    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].we, tbl[i].sel, tbl[i].val, tbl[i].rdy);
      tick();
      chk($sformatf("tv%0d_valid", i), 64'(mem_valid), 64'(tbl[i].e_valid));
      chk($sformatf("tv%0d_count", i), 64'(count), 64'(tbl[i].e_count));
      chk($sformatf("tv%0d_full", i), 64'(full), 64'(tbl[i].e_full));
      chk($sformatf("tv%0d_ovf", i), 64'(overflow), 64'(tbl[i].e_ovf));
      if (tbl[i].e_valid) begin
        chk($sformatf("tv%0d_addr", i), 64'(mem_addr), 64'(tbl[i].e_addr));
        chk($sformatf("tv%0d_data", i), 64'(mem_data), 64'(tbl[i].e_data));
      end
    end

    // Push and pop together while full: entry addr 4 goes in, count stays 4
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 2'(i), 32'(i + 1), 0);
      tick();
    end
    drive(1, 2'd0, 32'h55, 1);
    tick();
    chk("fpp_count", 64'(count), 64'd4);
    chk("fpp_ovf", 64'(overflow), 64'd0);
    chk("fpp_head", 64'(mem_addr), 64'd1);
    drive(0, 2'd0, 32'h0, 1);
    for (int i = 0; i < 3; i++) tick();
    chk("fpp_last_addr", 64'(mem_addr), 64'd4);
    chk("fpp_last_data", 64'(mem_data), 64'h55);
    chk("fpp_last_cnt", 64'(count), 64'd1);
    // count=1 with simultaneous push/pop: new entry becomes head
    drive(1, 2'd3, 32'h77, 1);
    tick();
    chk("c1_addr", 64'(mem_addr), 64'd5);
    chk("c1_count", 64'(count), 64'd1);

    // Address counter wrap over 257 pushes
    do_reset();
    for (int i = 0; i < 260; i++) begin
      drive(1, 2'($urandom_range(0, 3)), $urandom, 1);
      tick();
      if (i == 255) chk("wrap_ff", 64'(mem_addr), 64'hFF);
      if (i == 256) chk("wrap_00", 64'(mem_addr), 64'h00);
    end

    // Asynchronous reset with three entries and overflow set
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1, 2'd1, 32'(i + 10), 0);
      tick();
    end
    drive(0, 2'd0, 32'h0, 1);
    tick();
    drive(0, 2'd0, 32'h0, 0);
    chk("pre_rst_cnt", 64'(count), 64'd3);
    chk("pre_rst_ovf", 64'(overflow), 64'd1);
    #3;
    Rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(mem_valid), 64'd0);
    chk("arst_count", 64'(count), 64'd0);
    chk("arst_ovf", 64'(overflow), 64'd0);
    chk("arst_empty", 64'(empty), 64'd1);
    model_reset();
    @(posedge Clk);
    #1;
    Rst_n = 1'b1;
    drive(1, 2'd2, 32'hCAFE, 0);
    tick();
    chk("arst_addr0", 64'(mem_addr), 64'h00);

`ifdef STORE_BUF_PARITY_EN
    do_reset();
    drive(1, 2'd0, 32'h7, 0);
    tick();
    drive(1, 2'd1, 32'h3, 0);
    tick();
    chk("par7", 64'(mem_parity), 64'd1);
    drive(0, 2'd0, 32'h0, 1);
    tick();
    chk("par3", 64'(mem_parity), 64'd0);
`endif

    // Random traffic in phases of differing push/pop bias
    do_reset();
    for (int ph = 0; ph < 4; ph++) begin
      for (int i = 0; i < 600; i++) begin
        int wp, rp;
        wp = (ph == 1) ? 85 : (ph == 2) ? 20 : 55;
        rp = (ph == 1) ? 20 : (ph == 2) ? 85 : 50;
        drive($urandom_range(0, 99) < wp, 2'($urandom_range(0, 3)),
              $urandom, $urandom_range(0, 99) < rp);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
